// File: rtl/demux_route_sequencer.sv
// Purpose: buffers routed bit requests {chan,data} in a DEPTH-entry FIFO and drives the
//          1x8 demux select (s2..s0) and data (dout) for HOLD cycles per request, in order.
// Latency: a request accepted into an empty, idle block is driven from the next edge; sustained rate is one request per HOLD cycles.
// Backpressure: in_ready drops while the FIFO is full (level == DEPTH) or while rst is high.
//
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    - request handshake; transfer when both are high at a rising edge
//   in_chan[2:0], in_data - destination channel and bit to route
//   s2, s1, s0, dout     - registered demux select (s2 = MSB) and data
//   active               - select/data carry a live request this cycle
//   done                 - high on the final HOLD cycle of each request
//   level                - FIFO occupancy, 0..DEPTH
//
// Optional feature: define DSEQ_IDLE_PARK_EN to clear the select to channel 0 on entering
// IDLE. When it is undefined, the select keeps the last channel. In both builds dout is
// cleared on entering IDLE.
module demux_route_sequencer #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_chan,
    input  logic                       in_data,
    output logic                       s2,
    output logic                       s1,
    output logic                       s0,
    output logic                       dout,
    output logic                       active,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    HOLD_M1 = 8'(HOLD - 1);
    localparam logic [LW-1:0] FULL    = LW'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_DRIVE
    } state_t;

    // FIFO storage: {chan[2:0], data}
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          dout_q, dout_d;

    logic          push;
    logic          pop;
    logic          last_cycle;
    logic [3:0]    head;

    always_comb begin
        in_ready   = (level_q != FULL) && !rst;
        push       = in_valid && in_ready;
        last_cycle = (state_q == ST_DRIVE) && (cnt_q == 8'd0);
        // A pop happens when idle with data waiting, or on the final cycle of a request
        // with the next request already queued (no gap cycle between requests).
        pop        = (level_q != '0) && ((state_q == ST_IDLE) || last_cycle);
        head       = mem_q[rd_ptr_q];
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Sequencer FSM: outputs only change on a pop or on the transition into IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_DRIVE;
                    cnt_d   = HOLD_M1;
                    sel_d   = head[3:1];
                    dout_d  = head[0];
                end
            end
            ST_DRIVE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (pop) begin
                    cnt_d  = HOLD_M1;
                    sel_d  = head[3:1];
                    dout_d = head[0];
                end else begin
                    state_d = ST_IDLE;
                    dout_d  = 1'b0;
`ifdef DSEQ_IDLE_PARK_EN
                    sel_d   = 3'b000;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            sel_q    <= 3'b000;
            dout_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_chan, in_data};
        end
    end

    assign s2     = sel_q[2];
    assign s1     = sel_q[1];
    assign s0     = sel_q[0];
    assign dout   = dout_q;
    assign active = (state_q == ST_DRIVE);
    assign done   = last_cycle;
    assign level  = level_q;

endmodule
